demux_4: RTL and testbench

- Registered 1-to-4 demultiplexer; the write-side counterpart of mux_4.
- Accepts one data word per cycle on a valid/ready input channel and steers it to one of four output channels chosen by `select`.
- Each output channel has a single-entry holding register with its own valid/ready handshake.
- Used to dispatch results (e.g. writeback, unit issue) from one producer to four consumers, with full throughput and one cycle of latency.

---
 rtl/demux_4.sv | 90 +++++++++
 tb/tb_demux_4.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_4.sv
// Registered 1-to-4 demultiplexer: one valid/ready producer steered by `select`
// into four single-entry holding registers, each with its own valid/ready drain.
module demux_4 #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] data_in,
  input  logic [1:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] data_0,
  output logic [width-1:0] data_1,
  output logic [width-1:0] data_2,
  output logic [width-1:0] data_3,
  output logic             valid_0,
  output logic             valid_1,
  output logic             valid_2,
  output logic             valid_3,
  input  logic             ready_0,
  input  logic             ready_1,
  input  logic             ready_2,
  input  logic             ready_3,
  output logic [2:0]       occupancy
);

  localparam int unsigned NUM_CH = 4;

  logic [NUM_CH-1:0] valid_q;
  logic [NUM_CH-1:0] valid_d;
  logic [width-1:0]  data_q [NUM_CH];
  logic [width-1:0]  data_d [NUM_CH];

  logic [NUM_CH-1:0] ready_vec_c;
  logic [NUM_CH-1:0] drain_c;
  logic [NUM_CH-1:0] load_c;
  logic              accept_c;

  // Handshake decode: input readiness depends only on the addressed channel.
  always_comb begin
    ready_vec_c = {ready_3, ready_2, ready_1, ready_0};
    in_ready    = !valid_q[select] | ready_vec_c[select];
    accept_c    = in_valid & in_ready;
    drain_c     = valid_q & ready_vec_c;
    load_c      = accept_c ? (NUM_CH'(1) << select) : '0;
  end

  // Next state per channel: a load wins over a same-cycle drain; drains keep data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load_c[i]) begin
        data_d[i]  = data_in;
        valid_d[i] = 1'b1;
      end else if (drain_c[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  // Holding registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Output mapping and occupancy count from the registered valids.
  always_comb begin
    data_0    = data_q[0];
    data_1    = data_q[1];
    data_2    = data_q[2];
    data_3    = data_q[3];
    valid_0   = valid_q[0];
    valid_1   = valid_q[1];
    valid_2   = valid_q[2];
    valid_3   = valid_q[3];
    occupancy = 3'(valid_q[0]) + 3'(valid_q[1]) + 3'(valid_q[2]) + 3'(valid_q[3]);
  end

endmodule

// File: tb/tb_demux_4.sv
// Self-checking bench for demux_4: directed scenarios followed by random traffic,
// all compared against a per-channel mailbox model.
module tb_demux_4;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic [1:0]  select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_0, data_1, data_2, data_3;
  logic        valid_0, valid_1, valid_2, valid_3;
  logic [3:0]  rdy;
  logic [2:0]  occupancy;

  int errors = 0;
  int checks = 0;

  // Reference model: each channel is a one-slot mailbox remembering its last word.
  bit          m_full [4];
  logic [31:0] m_word [4];
  bit          stalled;

  logic [31:0] d_o [4];
  logic [3:0]  v_o;

  demux_4 #(.width(32)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .select(select),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
    .ready_0(rdy[0]), .ready_1(rdy[1]), .ready_2(rdy[2]), .ready_3(rdy[3]),
    .occupancy(occupancy)
  );

  assign d_o[0] = data_0;
  assign d_o[1] = data_1;
  assign d_o[2] = data_2;
  assign d_o[3] = data_3;
  assign v_o    = {valid_3, valid_2, valid_1, valid_0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int x = 0; x < 4; x++) begin
      m_full[x] = 0;
      m_word[x] = '0;
    end
    stalled = 0;
  endtask

  function automatic bit model_in_ready();
    return !m_full[select] || rdy[select];
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int x = 0; x < 4; x++) n += int'(m_full[x]);
    return n;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_in_ready()));
    for (int x = 0; x < 4; x++) begin
      chk($sformatf("%s.valid_%0d", tag, x), 32'(v_o[x]), 32'(m_full[x]));
      chk($sformatf("%s.data_%0d", tag, x), d_o[x], m_word[x]);
    end
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(model_count()));
  endtask

  // One clock: advance the model at the rising edge, return at the falling edge.
  task automatic cycle();
    bit acc;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      acc = in_valid && model_in_ready();
      stalled = in_valid && !acc;
      for (int x = 0; x < 4; x++) begin
        if (acc && int'(select) == x) begin
          m_word[x] = data_in;
          m_full[x] = 1;
        end else if (m_full[x] && rdy[x]) begin
          m_full[x] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [31:0] d);
    in_valid = v;
    select   = s;
    data_in  = d;
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    rdy   = 4'b0000;
    drive(1, 2'd2, 32'hA5A5_A5A5);

    // Reset state with a pending request on channel 2.
    repeat (2) @(negedge clk);
    #1;
    check_all("reset");
    chk("reset.in_ready_const", 32'(in_ready), 32'd1);

    rst_n = 1'b1;
    cycle();
    #1;
    check_all("first_accept");
    chk("first_accept.data_2", data_2, 32'hA5A5_A5A5);
    chk("first_accept.occ", 32'(occupancy), 32'd1);

    // Empty channel 2, then fill all four channels with no consumer ready.
    drive(0, 2'd0, 32'd0);
    rdy = 4'b0100;
    cycle();
    rdy = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'(k), 32'(10 * (k + 1)));
      cycle();
    end
    drive(0, 2'd0, 32'd0);
    #1;
    check_all("routing");
    chk("routing.occ", 32'(occupancy), 32'd4);
    drive(1, 2'd1, 32'd99);
    #1;
    chk("routing.blocked_ready", 32'(in_ready), 32'd0);
    cycle();
    #1;
    check_all("routing.blocked");
    chk("routing.data_1_kept", data_1, 32'd20);

    // Backpressure isolation: free channel 0, channel 3 stays full and stalled.
    drive(0, 2'd0, 32'd0);
    rdy = 4'b0001;
    cycle();
    rdy = 4'b0000;
    drive(1, 2'd0, 32'd7);
    #1;
    chk("isolate.in_ready", 32'(in_ready), 32'd1);
    cycle();
    drive(0, 2'd0, 32'd0);
    #1;
    check_all("isolate");
    chk("isolate.data_0", data_0, 32'd7);
    chk("isolate.valid_3", 32'(valid_3), 32'd1);

    // Throughput: drain everything, then stream 1..8 into channel 1 with ready_1 held.
    rdy = 4'b1111;
    cycle();
    rdy = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      drive(1, 2'd1, 32'(k));
      #1;
      chk("stream.in_ready", 32'(in_ready), 32'd1);
      cycle();
      #1;
      check_all("stream");
      chk("stream.data_1", data_1, 32'(k));
      chk("stream.occ", 32'(occupancy), 32'd1);
    end
    drive(0, 2'd0, 32'd0);
    cycle();
    #1;
    chk("stream_end.occ", 32'(occupancy), 32'd0);

    // Replace-while-draining on channel 2.
    rdy = 4'b0000;
    drive(1, 2'd2, 32'd55);
    cycle();
    rdy = 4'b0100;
    drive(1, 2'd2, 32'd66);
    cycle();
    drive(0, 2'd0, 32'd0);
    rdy = 4'b0000;
    #1;
    check_all("replace");
    chk("replace.data_2", data_2, 32'd66);
    chk("replace.valid_2", 32'(valid_2), 32'd1);

    // Simultaneous drain of channels 0 and 3; data must be retained.
    drive(1, 2'd0, 32'h111);
    cycle();
    drive(1, 2'd3, 32'h333);
    cycle();
    drive(0, 2'd0, 32'd0);
    rdy = 4'b1001;
    cycle();
    rdy = 4'b0000;
    #1;
    check_all("dual_drain");
    chk("dual_drain.data_0", data_0, 32'h111);
    chk("dual_drain.data_3", data_3, 32'h333);

    // Asynchronous reset mid-operation with three channels full and a stalled input.
    drive(1, 2'd0, 32'hA0);
    cycle();
    drive(1, 2'd1, 32'hA1);
    cycle();
    drive(1, 2'd1, 32'hBAD);
    #1;
    chk("midreset.pre_occ", 32'(occupancy), 32'd3);
    chk("midreset.stall", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all("midreset.async");
    chk("midreset.occ", 32'(occupancy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 2'd0, 32'd0);
    cycle();
    #1;
    check_all("midreset.after");
    chk("midreset.valid_1", 32'(valid_1), 32'd0);

    // Random traffic; a stalled request keeps its data and select stable.
    stalled = 0;
    for (int n = 0; n < 400; n++) begin
      if (!stalled) drive(1'($urandom), 2'($urandom), $urandom);
      rdy = 4'($urandom);
      #1;
      check_all("random");
      cycle();
    end
    drive(0, 2'd0, 32'd0);
    #1;
    check_all("random_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
